// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - instruction sequencer FSM: fetch/decode/exec/mem/wb/halt with nzp flags
// Two-process FSM; strobes are decoded from the registered state plus live handshake inputs.
module ctrl_sequencer (
  input  logic        clka,
  input  logic        reset_in,
  input  logic        run_in,
  input  logic [15:0] instr_in,
  input  logic        mem_ready_in,
  input  logic        n_alu_in,
  input  logic        z_alu_in,
  input  logic        p_alu_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic        ld_ir_out,
  output logic        ld_pc_out,
  output logic [1:0]  pc_ctl_out,
  output logic        we_reg_out,
  output logic [2:0]  nzp_out,
  output logic [2:0]  state_out,
  output logic        halt_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_MEM    = 3'b100,
    S_WB     = 3'b101,
    S_HALT   = 3'b110
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t      state;
  state_t      next_state;
  state_t      done_state;
  logic [3:0]  opcode;
  logic [2:0]  mask;
  logic [2:0]  nzp;
  logic [2:0]  alu_flags;
  logic        flags_onehot;
  logic        unused_instr;

  assign unused_instr = ^instr_in[8:0];
  assign alu_flags    = {n_alu_in, z_alu_in, p_alu_in};
  assign flags_onehot = (alu_flags == 3'b100) || (alu_flags == 3'b010) || (alu_flags == 3'b001);
  assign done_state   = run_in ? S_FETCH : S_IDLE;
  assign state_out    = state;
  assign nzp_out      = nzp;

  always_ff @(posedge clka) begin
    if (!reset_in) begin
      state  <= S_IDLE;
      opcode <= 4'b0000;
      mask   <= 3'b000;
      nzp    <= 3'b010;
    end else begin
      state <= next_state;
      if (state == S_FETCH && mem_ready_in) begin
        opcode <= instr_in[15:12];
        mask   <= instr_in[11:9];
      end
      if (we_reg_out && flags_onehot)
        nzp <= alu_flags;
    end
  end

  always_comb begin
    next_state  = state;
    mem_req_out = 1'b0;
    mem_we_out  = 1'b0;
    ld_ir_out   = 1'b0;
    ld_pc_out   = 1'b0;
    pc_ctl_out  = 2'b00;
    we_reg_out  = 1'b0;
    halt_out    = 1'b0;
    case (state)
      S_IDLE: begin
        if (run_in)
          next_state = S_FETCH;
      end
      S_FETCH: begin
        mem_req_out = 1'b1;
        if (mem_ready_in) begin
          ld_ir_out  = 1'b1;
          ld_pc_out  = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: next_state = S_EXEC;
          OP_LD, OP_ST:           next_state = S_MEM;
          OP_HLT:                 next_state = S_HALT;
          OP_BR: begin
            if (|(mask & nzp)) begin
              ld_pc_out  = 1'b1;
              pc_ctl_out = 2'b01;
            end
            next_state = done_state;
          end
          default:                next_state = done_state;
        endcase
      end
      S_EXEC: begin
        we_reg_out = 1'b1;
        next_state = done_state;
      end
      S_MEM: begin
        mem_req_out = 1'b1;
        mem_we_out  = (opcode == OP_ST);
        if (mem_ready_in)
          next_state = (opcode == OP_LD) ? S_WB : done_state;
      end
      S_WB: begin
        we_reg_out = 1'b1;
        next_state = done_state;
      end
      S_HALT: begin
        halt_out = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - directed per-cycle trace table plus halt/reset corner sequences
module tb_ctrl_sequencer;

  logic        clka = 1'b0;
  logic        reset_in, run_in, mem_ready_in;
  logic [15:0] instr_in;
  logic [2:0]  flags;
  logic        mem_req_out, mem_we_out, ld_ir_out, ld_pc_out, we_reg_out, halt_out;
  logic [1:0]  pc_ctl_out;
  logic [2:0]  nzp_out, state_out;

  int tests = 0;
  int fails = 0;

  always #5 clka = ~clka;

  ctrl_sequencer dut (
    .clka(clka), .reset_in(reset_in), .run_in(run_in), .instr_in(instr_in),
    .mem_ready_in(mem_ready_in), .n_alu_in(flags[2]), .z_alu_in(flags[1]), .p_alu_in(flags[0]),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .ld_ir_out(ld_ir_out),
    .ld_pc_out(ld_pc_out), .pc_ctl_out(pc_ctl_out), .we_reg_out(we_reg_out),
    .nzp_out(nzp_out), .state_out(state_out), .halt_out(halt_out)
  );

  typedef struct {
    logic        rst, run;
    logic [15:0] instr;
    logic        rdy;
    logic [2:0]  fl;
    logic [13:0] exp;   // {state, req, we, ld_ir, ld_pc, pc_ctl, we_reg, nzp, halt}
  } vec_t;

  vec_t tbl[$];

  localparam logic [2:0] IDL = 3'd0, FET = 3'd1, DEC = 3'd2, EXE = 3'd3, MEM = 3'd4, WBK = 3'd5, HLT = 3'd6;

  task automatic add(input logic rst, run, input logic [15:0] instr, input logic rdy,
                     input logic [2:0] fl, input logic [2:0] st, input logic req, we, ir, pc,
                     input logic [1:0] ctl, input logic wr, input logic [2:0] nzp, input logic h);
    vec_t v;
    v.rst = rst; v.run = run; v.instr = instr; v.rdy = rdy; v.fl = fl;
    v.exp = {st, req, we, ir, pc, ctl, wr, nzp, h};
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, run, input logic [15:0] instr, input logic rdy,
                       input logic [2:0] fl);
    #1;
    reset_in = rst; run_in = run; instr_in = instr; mem_ready_in = rdy; flags = fl;
    @(negedge clka);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {state_out, mem_req_out, mem_we_out, ld_ir_out, ld_pc_out, pc_ctl_out,
            we_reg_out, nzp_out, halt_out};
  endfunction

  initial begin
    reset_in = 1'b0; run_in = 1'b1; instr_in = '0; mem_ready_in = 1'b0; flags = '0;
    //   rst run instr    rdy fl       st  req we ir pc ctl    wr nzp     h
    add(0, 1, 16'h0000, 0, 3'b000, IDL, 0, 0, 0, 0, 2'b00, 0, 3'b010, 0);
    add(1, 1, 16'h0000, 0, 3'b000, IDL, 0, 0, 0, 0, 2'b00, 0, 3'b010, 0);
    add(1, 1, 16'h1234, 0, 3'b000, FET, 1, 0, 0, 0, 2'b00, 0, 3'b010, 0);
    add(1, 1, 16'h1234, 0, 3'b000, FET, 1, 0, 0, 0, 2'b00, 0, 3'b010, 0);
    add(1, 1, 16'h1234, 0, 3'b000, FET, 1, 0, 0, 0, 2'b00, 0, 3'b010, 0);
    add(1, 1, 16'h1234, 1, 3'b000, FET, 1, 0, 1, 1, 2'b00, 0, 3'b010, 0);
    add(1, 1, 16'h0000, 0, 3'b100, DEC, 0, 0, 0, 0, 2'b00, 0, 3'b010, 0);
    add(1, 1, 16'h0000, 0, 3'b100, EXE, 0, 0, 0, 0, 2'b00, 1, 3'b010, 0);
    add(1, 1, 16'h0800, 1, 3'b000, FET, 1, 0, 1, 1, 2'b00, 0, 3'b100, 0);
    add(1, 1, 16'h0000, 0, 3'b000, DEC, 0, 0, 0, 1, 2'b01, 0, 3'b100, 0);
    add(1, 1, 16'h0600, 1, 3'b000, FET, 1, 0, 1, 1, 2'b00, 0, 3'b100, 0);
    add(1, 1, 16'h0000, 1, 3'b000, DEC, 0, 0, 0, 0, 2'b00, 0, 3'b100, 0);
    add(1, 1, 16'h2000, 1, 3'b000, FET, 1, 0, 1, 1, 2'b00, 0, 3'b100, 0);
    add(1, 1, 16'h0000, 0, 3'b000, DEC, 0, 0, 0, 0, 2'b00, 0, 3'b100, 0);
    add(1, 1, 16'h0000, 1, 3'b000, MEM, 1, 0, 0, 0, 2'b00, 0, 3'b100, 0);
    add(1, 1, 16'h0000, 0, 3'b001, WBK, 0, 0, 0, 0, 2'b00, 1, 3'b100, 0);
    add(1, 1, 16'h3000, 1, 3'b000, FET, 1, 0, 1, 1, 2'b00, 0, 3'b001, 0);
    add(1, 1, 16'h0000, 0, 3'b000, DEC, 0, 0, 0, 0, 2'b00, 0, 3'b001, 0);
    add(1, 1, 16'h0000, 1, 3'b100, MEM, 1, 1, 0, 0, 2'b00, 0, 3'b001, 0);
    add(1, 1, 16'h5000, 1, 3'b000, FET, 1, 0, 1, 1, 2'b00, 0, 3'b001, 0);
    add(1, 1, 16'h0000, 0, 3'b000, DEC, 0, 0, 0, 0, 2'b00, 0, 3'b001, 0);
    add(1, 0, 16'h0000, 0, 3'b110, EXE, 0, 0, 0, 0, 2'b00, 1, 3'b001, 0);
    add(1, 0, 16'h0000, 1, 3'b000, IDL, 0, 0, 0, 0, 2'b00, 0, 3'b001, 0);
    add(1, 1, 16'h0000, 0, 3'b000, IDL, 0, 0, 0, 0, 2'b00, 0, 3'b001, 0);
    add(1, 1, 16'h7000, 1, 3'b000, FET, 1, 0, 1, 1, 2'b00, 0, 3'b001, 0);
    add(1, 1, 16'h0000, 0, 3'b000, DEC, 0, 0, 0, 0, 2'b00, 0, 3'b001, 0);
    add(1, 1, 16'h0E00, 1, 3'b000, FET, 1, 0, 1, 1, 2'b00, 0, 3'b001, 0);
    add(1, 1, 16'h0000, 0, 3'b000, DEC, 0, 0, 0, 1, 2'b01, 0, 3'b001, 0);
    add(1, 1, 16'h9000, 1, 3'b000, FET, 1, 0, 1, 1, 2'b00, 0, 3'b001, 0);
    add(1, 1, 16'h0000, 0, 3'b000, DEC, 0, 0, 0, 0, 2'b00, 0, 3'b001, 0);
    add(1, 1, 16'h0000, 0, 3'b010, EXE, 0, 0, 0, 0, 2'b00, 1, 3'b001, 0);
    add(1, 1, 16'h0000, 1, 3'b000, FET, 1, 0, 1, 1, 2'b00, 0, 3'b010, 0);
    add(1, 0, 16'h0000, 0, 3'b000, DEC, 0, 0, 0, 0, 2'b00, 0, 3'b010, 0);
    add(1, 0, 16'h0000, 0, 3'b000, IDL, 0, 0, 0, 0, 2'b00, 0, 3'b010, 0);

    @(posedge clka);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].run, tbl[i].instr, tbl[i].rdy, tbl[i].fl);
      chk($sformatf("row%0d", i), {18'd0, outs()}, {18'd0, tbl[i].exp});
      @(posedge clka);
    end

    // HALT entry, run_in ignored, exit only through reset
    drive(1, 1, 16'h0000, 0, 3'b000); chk("halt_idle", state_out, IDL); @(posedge clka);
    drive(1, 1, 16'hF000, 1, 3'b000); chk("halt_fetch_ldir", ld_ir_out, 1); @(posedge clka);
    drive(1, 0, 16'h0000, 0, 3'b000); chk("halt_decode", state_out, DEC); @(posedge clka);
    for (int k = 0; k < 3; k++) begin
      drive(1, k[0], 16'h0000, 1, 3'b100);
      chk("halt_state", state_out, HLT);
      chk("halt_flag", halt_out, 1);
      chk("halt_strobes", {mem_req_out, ld_ir_out, ld_pc_out, we_reg_out}, 4'b0000);
      @(posedge clka);
    end
    drive(0, 1, 16'h0000, 0, 3'b000); @(posedge clka);
    drive(1, 1, 16'h0000, 0, 3'b000);
    chk("halt_reset_state", state_out, IDL);
    chk("halt_reset_flag", halt_out, 0);
    chk("halt_reset_nzp", nzp_out, 3'b010);
    @(posedge clka);

    // reset during a stalled MEM access drops the request
    drive(1, 1, 16'h2000, 1, 3'b000); chk("mrst_fetch", state_out, FET); @(posedge clka);
    drive(1, 1, 16'h0000, 0, 3'b000); chk("mrst_decode", state_out, DEC); @(posedge clka);
    drive(1, 1, 16'h0000, 0, 3'b000); chk("mrst_mem_req", {state_out, mem_req_out, mem_we_out}, {MEM, 2'b10}); @(posedge clka);
    drive(1, 1, 16'h0000, 0, 3'b000); chk("mrst_mem_hold", {state_out, mem_req_out}, {MEM, 1'b1}); @(posedge clka);
    drive(0, 1, 16'h0000, 0, 3'b000); chk("mrst_mem_pre", mem_req_out, 1); @(posedge clka);
    drive(1, 0, 16'h0000, 0, 3'b000);
    chk("mrst_idle", state_out, IDL);
    chk("mrst_req_drop", mem_req_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
